// File: rtl/lcd_page_buf.sv
// Fetches eight 64-pixel ROM rows for one LCD page and streams them as 64 transposed KS0108 column bytes.
// Ack 10 cycles after request, each byte held 2 cycles; the stream runs unthrottled once the request falls.
module lcd_page_buf #(
  parameter int IMG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_request,
  input  logic [IMG_W+2:0] addr,
  output logic             data_ack,
  output logic [7:0]       data,
  output logic             rom_en,
  output logic [IMG_W+5:0] rom_addr,
  input  logic [63:0]      rom_data
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FETCH  = 2'd1;
  localparam logic [1:0] ACK    = 2'd2;
  localparam logic [1:0] STREAM = 2'd3;

  logic [1:0]       state;
  logic [IMG_W-1:0] img;
  logic [2:0]       page;
  logic [3:0]       fc;
  logic [6:0]       sc;
  logic [5:0]       nxt_idx;
  logic [63:0]      rows [8];
  logic [7:0]       first_byte;
  logic [7:0]       stream_byte;

  assign data_ack = (state == ACK);
  assign rom_en   = (state == FETCH) && !fc[3];
  assign rom_addr = rom_en ? {img, page, fc[2:0]} : '0;

  // sc counts cycles since acceptance, so the byte shown next cycle is (sc+1)/2.
  assign nxt_idx = sc[6:1] + {5'd0, sc[0]};

  // Byte 0 is built while row 7 is still on the ROM bus so it is ready on the first ACK cycle.
  always_comb begin
    first_byte  = '0;
    stream_byte = '0;
    for (int i = 0; i < 8; i++) begin
      first_byte[i]  = (i == 7) ? rom_data[63] : rows[i][63];
      stream_byte[i] = rows[i][~nxt_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      img   <= '0;
      page  <= '0;
      fc    <= '0;
      sc    <= '0;
      data  <= '0;
      for (int i = 0; i < 8; i++) begin
        rows[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (data_request) begin
            img   <= addr[IMG_W+2:3];
            page  <= addr[2:0];
            fc    <= '0;
            state <= FETCH;
          end
        end
        FETCH: begin
          if (!data_request) begin
            state <= IDLE;
          end else begin
            if (fc != 4'd0) begin
              rows[fc[2:0] - 3'd1] <= rom_data;
            end
            if (fc == 4'd8) begin
              data  <= first_byte;
              state <= ACK;
            end else begin
              fc <= fc + 4'd1;
            end
          end
        end
        ACK: begin
          if (!data_request) begin
            sc    <= 7'd1;
            state <= STREAM;
          end else begin
            sc <= '0;
          end
        end
        STREAM: begin
          if (sc == 7'd127) begin
            state <= IDLE;
          end else begin
            sc   <= sc + 7'd1;
            data <= stream_byte;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_page_buf.sv
// Directed bench for lcd_page_buf: fetch timing, transposition, stream cadence, abort, hold and reset.
module tb_lcd_page_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_request;
  logic [6:0]  addr;
  logic        data_ack;
  logic [7:0]  data;
  logic        rom_en;
  logic [9:0]  rom_addr;
  logic [63:0] rom_data;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_col [64];

  lcd_page_buf #(.IMG_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_request (data_request),
    .addr         (addr),
    .data_ack     (data_ack),
    .data         (data),
    .rom_en       (rom_en),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data)
  );

  always #5 clk = ~clk;

  // Image 0: single diagonal pixel per row; image 1 page 5: all ones; else rotated pattern.
  function automatic logic [63:0] rom_fn(input logic [9:0] a);
    logic [63:0] base;
    int s;
    base = 64'h0123_4567_89AB_CDEF;
    s = int'(a[5:0]);
    if (a[9:6] == 4'd0) return 64'h8000_0000_0000_0000 >> a[2:0];
    if (a[9:6] == 4'd1 && a[5:3] == 3'd5) return '1;
    return (base << s) | (base >> (64 - s));
  endfunction

  always @(posedge clk) begin
    if (rst) rom_data <= '0;
    else if (rom_en) rom_data <= rom_fn(rom_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_exp_basic();
    for (int k = 0; k < 64; k++) exp_col[k] = (k < 8) ? 8'(1 << k) : 8'h00;
  endtask

  task automatic set_exp_const(input logic [7:0] v);
    for (int k = 0; k < 64; k++) exp_col[k] = v;
  endtask

  task automatic set_exp_model(input logic [3:0] im, input logic [2:0] pg);
    logic [63:0] r;
    for (int y = 0; y < 64; y++) begin
      for (int i = 0; i < 8; i++) begin
        r = rom_fn({im, pg, 3'(i)});
        exp_col[y][i] = r[63 - y];
      end
    end
  endtask

  // Called in cycle R; returns in cycle R+10 with the ack up and request still high.
  task automatic fetch_page(input logic [6:0] a);
    addr = a;
    data_request = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("fetch_rom_en", rom_en, 1);
      check("fetch_rom_addr", rom_addr, {a, 3'(k)});
      check("fetch_ack_low", data_ack, 0);
    end
    tick();
    check("fetch_tail_en", rom_en, 0);
    check("fetch_tail_ack", data_ack, 0);
    tick();
    check("ack_rise", data_ack, 1);
    check("byte0_at_ack", data, exp_col[0]);
  endtask

  // Holds the request for 'hold' cycles, drops it (cycle A), then follows the stream to A+128.
  task automatic stream_page(input int hold, input bit early, input logic [6:0] nxt);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("ack_hold", data_ack, 1);
      check("byte0_hold", data, exp_col[0]);
    end
    data_request = 1'b0;
    for (int n = 1; n <= 127; n++) begin
      tick();
      check("stream_byte", data, exp_col[n >> 1]);
      check("stream_ack_low", data_ack, 0);
      if (early && n == 127) begin
        addr = nxt;
        data_request = 1'b1;
      end
    end
    tick();
    check("idle_rom_en", rom_en, 0);
    check("idle_ack", data_ack, 0);
    check("byte63_hold", data, exp_col[63]);
  endtask

  initial begin
    rst = 1'b1;
    data_request = 1'b0;
    addr = '0;
    tick();
    tick();
    check("rst_ack", data_ack, 0);
    check("rst_data", data, 8'h00);
    check("rst_rom_en", rom_en, 0);
    check("rst_rom_addr", rom_addr, 10'h000);
    rst = 1'b0;
    tick();

    // Basic fetch and cadence; request for image 1 page 5 raised in the last stream cycle.
    set_exp_basic();
    fetch_page(7'h00);
    stream_page(0, 1'b1, {4'd1, 3'd5});

    // Address mapping with all-ones rows, accepted straight from the IDLE return; ack held 7 cycles.
    set_exp_const(8'hFF);
    fetch_page({4'd1, 3'd5});
    stream_page(7, 1'b0, 7'h00);
    tick();

    // Abort: request dropped in cycle R+4.
    addr = 7'h00;
    data_request = 1'b1;
    tick();
    tick();
    tick();
    tick();
    check("abort_rom_en_r4", rom_en, 1);
    check("abort_rom_addr_r4", rom_addr, 10'h003);
    data_request = 1'b0;
    tick();
    check("abort_idle_en", rom_en, 0);
    check("abort_no_ack", data_ack, 0);
    for (int j = 0; j < 3; j++) begin
      tick();
      check("abort_ack_stays_low", data_ack, 0);
      check("abort_data_held", data, 8'hFF);
    end

    // Reset asserted at A+40, then a fresh basic fetch.
    set_exp_basic();
    fetch_page(7'h00);
    data_request = 1'b0;
    for (int n = 1; n < 40; n++) begin
      tick();
      check("pre_rst_byte", data, exp_col[n >> 1]);
    end
    tick();
    rst = 1'b1;
    #1;
    check("midrst_data", data, 8'h00);
    check("midrst_ack", data_ack, 0);
    check("midrst_rom_en", rom_en, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    fetch_page(7'h00);
    stream_page(0, 1'b0, 7'h00);

    // Back-to-back pages 0..7 of image 1 with varying controller gaps.
    for (int p = 0; p < 8; p++) begin
      set_exp_model(4'd1, 3'(p));
      fetch_page({4'd1, 3'(p)});
      if (p < 7 && (p % 2) == 0) begin
        stream_page(p % 3, 1'b1, {4'd1, 3'(p + 1)});
      end else begin
        stream_page(p % 3, 1'b0, 7'h00);
        for (int g = 0; g < p + 1; g++) tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lcd_page_buf.md
# lcd_page_buf

Page re-arrangement buffer on the responder side of the LCD controller's `data_request`/`data_ack` handshake. On request it fetches eight 64-pixel rows of one image page from a row-organised synchronous image ROM and transposes them into 64 column bytes in KS0108 page format. It then streams those bytes on `data` at the controller's two-clock `lcd_en` cadence. It sits between the image ROM and the LCD controller, on the same clock.

## Interface
- `IMG_W`, default 4: image-index width; `addr` = {image[IMG_W-1:0], page[2:0]}.
- `clk`  in  1  controller clock, same as LCD controller.
- `rst`  in  1  asynchronous reset, active-high.
- `data_request`  in  1  level request from LCD controller.
- `addr`  in  IMG_W+3  {image, page}, sampled when a request is accepted.
- `data_ack`  out  1  page ready; held until request drops.
- `data`  out  8  column byte to controller.
- `rom_en`  out  1  ROM read enable.
- `rom_addr`  out  IMG_W+6  {image, page, row[2:0]}.
- `rom_data`  in  64  ROM row; valid the cycle after `rom_en`/`rom_addr`. Bit 63 is the leftmost pixel (y=0).

## Operation
- Storage: eight 64-bit row registers `row0`..`row7`.
- Column byte y: bit i = `row_i[63-y]`. Bit 0 is the top row of the page.
- FSM states: IDLE, FETCH, ACK, STREAM.
- IDLE:
  - `data_ack`=0, `rom_en`=0.
  - On `data_request`=1: latch `addr` into img/page, clear fetch counter `fc`, go to FETCH.
- FETCH, with `fc` running 0..8:
  - For `fc`≤7: `rom_en`=1, `rom_addr`={img, page, fc[2:0]}.
  - For `fc`≥1: capture `rom_data` into `row[fc-1]`.
  - At `fc`=8, go to ACK.
  - If `data_request` is 0 in any FETCH cycle: abort to IDLE with no ack. Partial rows are discarded.
- ACK:
  - `data_ack`=1; `data` = column byte 0.
  - Stays in ACK while `data_request`=1.
  - The first ACK cycle with `data_request`=0 is acceptance cycle A. Go to STREAM and clear the 7-bit stream counter `sc`.
- STREAM:
  - `data_ack`=0.
  - Byte index = `sc[6:1]`; `sc` increments every cycle.
  - After `sc`=127, return to IDLE.
  - `data_request` is ignored during STREAM.
  - A request still high at the IDLE return is accepted the following cycle.
- `data` is registered. After a stream it holds byte 63 until the next ACK loads byte 0.
- `sc` never wraps inside a stream; it ends exactly at 127.

## Timing
- Reset (async, immediate):
  - State = IDLE.
  - `data_ack`=0, `data`=8'h00, `rom_en`=0, `rom_addr`=0.
  - Row registers cleared.
- Reset asserted mid-FETCH/ACK/STREAM: all outputs go to reset values immediately. The block restarts from IDLE after release.
- Request first seen high at cycle R:
  - FETCH occupies R+1..R+9.
  - ROM addresses are issued R+1..R+8; rows are captured R+2..R+9.
  - `data_ack` is high from R+10.
- Column byte k is on `data` during cycles A+2k and A+2k+1, for k=0..63. Byte 0 is already present from the first ACK cycle.
  - The controller samples at A+2k+1 (lcd_en-low cycles).
- STREAM ends after cycle A+127; IDLE is entered at A+128.
- Ack-to-request ordering: the controller samples `data_ack` only on alternate cycles, so `data_ack` stays high for as long as needed. The handshake completes on request fall, never on a timeout.
- Simultaneous `rst` and `data_request`: reset wins.

## Test plan
- Basic fetch:
  - Stimulus: reset; ROM row r of image 0, page 0 = 64'h8000_0000_0000_0000 >> r; raise request with `addr`=7'h00 at R.
  - Required: `rom_addr` sequence 0..7 in R+1..R+8; `data_ack` high at R+10.
  - Required: bytes 0..7 = 8'h01, 8'h02, …, 8'h80; bytes 8..63 = 0.
- Controller cadence: drop request at A.
  - Required: `data` changes only at A+2k; byte 63 lands at A+126..A+127.
  - Required: IDLE at A+128, `data_ack` low throughout STREAM.
- Address mapping:
  - Stimulus: `addr`={4'd1, 3'd5}.
  - Required: `rom_addr` = 10'h068..10'h06F.
  - Required: all-ones ROM rows give `data`=8'hFF for all 64 bytes.
- Abort and hold:
  - Stimulus: drop request at R+4.
    - Required: IDLE at R+5, no `data_ack`.
  - Stimulus: hold request high for 7 cycles after ack.
    - Required: `data_ack` stays high, byte 0 held, no STREAM until request falls.
- Reset mid-stream:
  - Stimulus: assert `rst` at A+40.
  - Required: `data`=0, `data_ack`=0 the same cycle; a fresh request after release repeats the basic-fetch timing.
- Back-to-back requests:
  - Stimulus: request pages 0..7 of image 1 with controller-model gaps.
  - Required: eight correct 64-byte transposed pages.
